alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width in bits (legal values 8 to 64).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, operands and opcode valid.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept an operation.
REQ-006 The block SHALL have port src_a, input, WIDTH, operand A.
REQ-007 The block SHALL have port src_b, input, WIDTH, operand B.
REQ-008 The block SHALL have port alu_control, input, 3, opcode per REQ-013.
REQ-009 The block SHALL have port flag_update, input, 1, S-bit: write flags on completion.
REQ-010 The block SHALL have port out_valid, output, 1, alu_result is valid.
REQ-011 The block SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 The block SHALL have ports alu_result (output, WIDTH, result) and alu_flags (output, 4, registered {N,Z,C,V}).

Function
REQ-013 Opcodes SHALL be: 000 ADD A+B; 001 SUB A-B; 010 AND; 011 ORR; 100 MOV (B); 101 CMP (A-B, flags always written); 110 MUL (low WIDTH bits of A*B); 111 reserved.
REQ-014 The FSM SHALL have states IDLE, MUL, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 An operation SHALL be accepted on a clock edge where in_valid and in_ready are both 1; operands and opcode SHALL be captured at that edge.
REQ-016 Non-MUL ops SHALL go IDLE->DONE, with alu_result registered at the accept edge (out_valid 1 cycle after accept).
REQ-017 MUL SHALL go IDLE->MUL, then perform radix-2 shift-add for exactly WIDTH cycles, then enter DONE (out_valid WIDTH+1 cycles after accept).
REQ-018 In DONE, alu_result and alu_flags SHALL hold stable until out_ready is 1; on that edge the FSM SHALL return to IDLE.
REQ-019 in_valid SHALL be ignored outside IDLE; there is no accept in the cycle where DONE completes.
REQ-020 Flags SHALL update only at entry to DONE, and only when flag_update=1 or opcode=CMP; otherwise alu_flags SHALL retain its value.
REQ-021 For ADD: C = carry out of bit WIDTH-1; V = signed overflow.
REQ-022 For SUB and CMP: C = NOT borrow (1 when A>=B unsigned); V = signed overflow.
REQ-023 For AND, ORR, MOV and MUL: N and Z are updated; C and V are retained.
REQ-024 For all flag-updating ops: N = result[WIDTH-1]; Z = (result==0).
REQ-025 CMP SHALL also drive A-B on alu_result.
REQ-026 Reserved opcode 111 SHALL complete like a single-cycle op with alu_result=0 and flags unchanged regardless of flag_update.

Reset
REQ-027 While reset=1, the block SHALL asynchronously force state IDLE, alu_result=0, alu_flags=4'b0000, out_valid=0, and the MUL accumulator and counter to 0; in_ready SHALL be 1 from the first edge after release.
REQ-028 Reset asserted during MUL or DONE SHALL abort the operation with no result delivered.

Configuration
REQ-029 With macro ALU_SEQ_MUL_EN defined, MUL SHALL behave per REQ-017; without it, the MUL state and multiplier logic SHALL be absent and opcode 110 SHALL behave as reserved per REQ-026.

Verification (WIDTH=32, ALU_SEQ_MUL_EN defined)
REQ-030 ADD 0x7FFFFFFF+0x00000001, flag_update=1 -> one cycle after accept: out_valid=1, alu_result=0x80000000, alu_flags=4'b1001.
REQ-031 CMP 5,5, flag_update=0 -> alu_result=0, alu_flags=4'b0110.
REQ-032 After REQ-031, SUB 3-5 with flag_update=0 -> alu_result=0xFFFFFFFE, alu_flags stays 4'b0110.
REQ-033 MUL 7*6, flag_update=1 -> in_ready=0 for 33 cycles, out_valid rises exactly 33 cycles after accept, alu_result=42, N=0, Z=0, C and V unchanged.
REQ-034 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> result and flags held, no new accept; out_ready=1 -> IDLE next cycle.
REQ-035 Assert reset at MUL cycle 10 -> alu_result=0, alu_flags=0 and out_valid=0 immediately (before the next clk edge); after release, no out_valid until a new accept.

Source files
------------

// File: rtl/alu_seq_if.sv
// Handshake and data bundle for alu_seq: operand/opcode request channel and result channel.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [2:0]       alu_control;
  logic             flag_update;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;

  modport master (
    output in_valid, src_a, src_b, alu_control, flag_update, out_ready,
    input  in_ready, out_valid, alu_result, alu_flags
  );

  modport slave (
    input  in_valid, src_a, src_b, alu_control, flag_update, out_ready,
    output in_ready, out_valid, alu_result, alu_flags
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake and registered {N,Z,C,V} flags.
// Define ALU_SEQ_MUL_EN to include the WIDTH-cycle shift-add multiplier (opcode 110).
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus
);

  if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $error("alu_seq: WIDTH must be in 8..64");
  end

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_MOV = 3'b100,
    OP_CMP = 3'b101,
    OP_MUL = 3'b110,
    OP_RSV = 3'b111
  } op_e;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DONE = 2'b10
  } state_e;
`else
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DONE = 1'b1
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  op_e              op;
  logic [WIDTH-1:0] a, b;
  logic [WIDTH:0]   sum_w, diff_w;
  logic             add_v, sub_v;
  logic [WIDTH-1:0] res_c;
  logic             c_c, v_c, we_c;
  logic [3:0]       flags_c;

  assign op     = op_e'(bus.alu_control);
  assign a      = bus.src_a;
  assign b      = bus.src_b;
  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};
  // Signed overflow: operands agree (add) / differ (sub) in sign and the result sign flips from A.
  assign add_v  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1]  != a[WIDTH-1]);
  assign sub_v  = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    res_c = '0;
    c_c   = flags_q[1];
    v_c   = flags_q[0];
    we_c  = bus.flag_update;
    unique case (op)
      OP_ADD: begin
        res_c = sum_w[WIDTH-1:0];
        c_c   = sum_w[WIDTH];
        v_c   = add_v;
      end
      OP_SUB: begin
        res_c = diff_w[WIDTH-1:0];
        c_c   = ~diff_w[WIDTH];
        v_c   = sub_v;
      end
      OP_CMP: begin
        res_c = diff_w[WIDTH-1:0];
        c_c   = ~diff_w[WIDTH];
        v_c   = sub_v;
        we_c  = 1'b1;
      end
      OP_AND: res_c = a & b;
      OP_ORR: res_c = a | b;
      OP_MOV: res_c = b;
      OP_MUL, OP_RSV: begin
        res_c = '0;
        we_c  = 1'b0;
      end
    endcase
  end

  assign flags_c = {res_c[WIDTH-1], (res_c == '0), c_c, v_c};

`ifdef ALU_SEQ_MUL_EN
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             upd_q, upd_d;
  logic [WIDTH-1:0] acc_nxt;

  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
`ifdef ALU_SEQ_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    upd_d    = upd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
`ifdef ALU_SEQ_MUL_EN
          if (op == OP_MUL) begin
            state_d  = S_MUL;
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            upd_d    = bus.flag_update;
          end else
`endif
          begin
            state_d  = S_DONE;
            result_d = res_c;
            if (we_c) flags_d = flags_c;
          end
        end
      end
`ifdef ALU_SEQ_MUL_EN
      // The final partial product is folded in on the same edge that enters DONE,
      // so WIDTH cycles are spent in MUL in total.
      S_MUL: begin
        acc_d    = acc_nxt;
        mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = S_DONE;
          result_d = acc_nxt;
          if (upd_q) flags_d = {acc_nxt[WIDTH-1], (acc_nxt == '0), flags_q[1:0]};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= '0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      upd_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
`ifdef ALU_SEQ_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      upd_q    <= upd_d;
`endif
    end
  end

  assign bus.in_ready   = (state_q == S_IDLE) && !reset;
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.alu_result = result_q;
  assign bus.alu_flags  = flags_q;

  a_ready_valid_excl: assert property (@(posedge clk) disable iff (reset)
    !(bus.in_ready && bus.out_valid));

  a_done_hold: assert property (@(posedge clk) disable iff (reset)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.alu_result) && $stable(bus.alu_flags)));

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq (WIDTH=32); MUL expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        fu;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at #1 after a posedge with the DUT idle; returns at #1 after the edge where DONE is seen.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic fu, output logic [31:0] r, output logic [3:0] f,
                        output int lat, output logic busy_ok);
    bus.alu_control = op;
    bus.src_a       = a;
    bus.src_b       = b;
    bus.flag_update = fu;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.in_ready) busy_ok = 1'b0;
    r = bus.alu_result;
    f = bus.alu_flags;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    logic        busy_ok;
    logic        seen;

    vecs[0]  = '{op:3'd0, a:32'h7FFFFFFF, b:32'h00000001, fu:1'b1, res:32'h80000000, flg:4'b1001, lat:1};
    vecs[1]  = '{op:3'd5, a:32'd5,        b:32'd5,        fu:1'b0, res:32'h00000000, flg:4'b0110, lat:1};
    vecs[2]  = '{op:3'd1, a:32'd3,        b:32'd5,        fu:1'b0, res:32'hFFFFFFFE, flg:4'b0110, lat:1};
    vecs[3]  = '{op:3'd1, a:32'd3,        b:32'd5,        fu:1'b1, res:32'hFFFFFFFE, flg:4'b1000, lat:1};
    vecs[4]  = '{op:3'd0, a:32'hFFFFFFFF, b:32'h00000001, fu:1'b1, res:32'h00000000, flg:4'b0110, lat:1};
    vecs[5]  = '{op:3'd2, a:32'hF0F0F0F0, b:32'hFF00FF00, fu:1'b1, res:32'hF000F000, flg:4'b1010, lat:1};
    vecs[6]  = '{op:3'd3, a:32'h00001234, b:32'h00004321, fu:1'b1, res:32'h00005335, flg:4'b0010, lat:1};
    vecs[7]  = '{op:3'd4, a:32'h0000DEAD, b:32'h00000000, fu:1'b1, res:32'h00000000, flg:4'b0110, lat:1};
    vecs[8]  = '{op:3'd1, a:32'h80000000, b:32'h00000001, fu:1'b1, res:32'h7FFFFFFF, flg:4'b0011, lat:1};
    vecs[9]  = '{op:3'd2, a:32'hFFFFFFFF, b:32'h00000000, fu:1'b0, res:32'h00000000, flg:4'b0011, lat:1};
    vecs[10] = '{op:3'd7, a:32'd5,        b:32'd6,        fu:1'b1, res:32'h00000000, flg:4'b0011, lat:1};
`ifdef ALU_SEQ_MUL_EN
    vecs[11] = '{op:3'd6, a:32'd7,        b:32'd6,        fu:1'b1, res:32'd42,       flg:4'b0011, lat:33};
    vecs[12] = '{op:3'd6, a:32'hFFFFFFFF, b:32'hFFFFFFFF, fu:1'b1, res:32'h00000001, flg:4'b0011, lat:33};
    vecs[13] = '{op:3'd6, a:32'h00010000, b:32'h00010000, fu:1'b1, res:32'h00000000, flg:4'b0111, lat:33};
`else
    vecs[11] = '{op:3'd6, a:32'd7,        b:32'd6,        fu:1'b1, res:32'h00000000, flg:4'b0011, lat:1};
    vecs[12] = '{op:3'd6, a:32'hFFFFFFFF, b:32'hFFFFFFFF, fu:1'b1, res:32'h00000000, flg:4'b0011, lat:1};
    vecs[13] = '{op:3'd6, a:32'h00010000, b:32'h00010000, fu:1'b1, res:32'h00000000, flg:4'b0011, lat:1};
`endif
    vecs[14] = '{op:3'd5, a:32'd1,        b:32'd2,        fu:1'b0, res:32'hFFFFFFFF, flg:4'b1000, lat:1};
    vecs[15] = '{op:3'd0, a:32'h80000000, b:32'h80000000, fu:1'b1, res:32'h00000000, flg:4'b0111, lat:1};
`ifdef ALU_SEQ_MUL_EN
    vecs[16] = '{op:3'd6, a:32'h80000000, b:32'd3,        fu:1'b1, res:32'h80000000, flg:4'b1011, lat:33};
`else
    vecs[16] = '{op:3'd6, a:32'h80000000, b:32'd3,        fu:1'b1, res:32'h00000000, flg:4'b0111, lat:1};
`endif

    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.src_a       = '0;
    bus.src_b       = '0;
    bus.alu_control = '0;
    bus.flag_update = 1'b0;
    bus.out_ready   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset result", bus.alu_result, 0);
    chk("reset flags", bus.alu_flags, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("in_ready after reset", bus.in_ready, 1);

    for (int i = 0; i < 17; i++) begin
      chk($sformatf("v%0d idle", i), bus.in_ready, 1);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fu, r, f, lat, busy_ok);
      chk($sformatf("v%0d result", i), r, vecs[i].res);
      chk($sformatf("v%0d flags", i), f, vecs[i].flg);
      chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d in_ready low while busy", i), busy_ok, 1);
      consume();
    end

    // DONE must hold against out_ready=0 while in_valid is asserted.
    bus.alu_control = 3'd0;
    bus.src_a       = 32'd1;
    bus.src_b       = 32'd2;
    bus.flag_update = 1'b1;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.src_a = 32'd100;
    bus.src_b = 32'd200;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d out_valid", k), bus.out_valid, 1);
      chk($sformatf("hold%0d in_ready", k), bus.in_ready, 0);
      chk($sformatf("hold%0d result", k), bus.alu_result, 32'd3);
      chk($sformatf("hold%0d flags", k), bus.alu_flags, 4'b0000);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("release out_valid", bus.out_valid, 0);
    chk("release in_ready", bus.in_ready, 1);
    chk("release no accept", bus.alu_result, 32'd3);
    @(posedge clk); #1;
    chk("release stays idle", bus.out_valid, 0);

    run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, r, f, lat, busy_ok);
    chk("pre-abort result", r, 32'hFFFFFFFE);
    chk("pre-abort flags", f, 4'b1010);
    consume();

    // Abort an in-flight operation with an asynchronous reset mid-cycle.
    bus.flag_update = 1'b1;
    bus.src_a       = 32'd7;
    bus.src_b       = 32'd6;
`ifdef ALU_SEQ_MUL_EN
    bus.alu_control = 3'd6;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mul cycle10 busy", bus.in_ready, 0);
    chk("mul cycle10 no out_valid", bus.out_valid, 0);
`else
    bus.alu_control = 3'd0;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("done before abort", bus.out_valid, 1);
`endif
    #2;
    reset = 1'b1;
    #1;
    chk("abort result", bus.alu_result, 0);
    chk("abort flags", bus.alu_flags, 0);
    chk("abort out_valid", bus.out_valid, 0);
    @(negedge clk) reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("no out_valid after abort", seen, 0);
    chk("idle after abort", bus.in_ready, 1);

    run_op(3'd0, 32'd2, 32'd3, 1'b0, r, f, lat, busy_ok);
    chk("post-abort result", r, 32'd5);
    chk("post-abort flags", f, 4'b0000);
    chk("post-abort latency", lat, 1);
    consume();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
